// File: rtl/load_align_unit.sv
// ---------------------------------------------------------------------------
// load_align_unit
//
// Load-data front end between the MEM stage and the L1 data cache. A load
// request (byte address + funct3) is turned into one or two word-aligned
// cache reads. The returned word(s) are merged, shifted down to the load
// offset, trimmed to the access size and sign/zero-extended.
// Boundary-crossing loads are either split into two reads
// (MISALIGNED_SPLIT=1) or reported as misaligned with no cache access
// (MISALIGNED_SPLIT=0).
//
// Parameters
//   XLEN             data/address width, 32 or 64
//   MISALIGNED_SPLIT 1 = split boundary-crossing loads, 0 = report them
//
// Ports
//   clock, reset       rising-edge clock, async active-low reset
//   req_valid/ready    load request handshake (ready only when idle)
//   req_funct3         load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   req_addr           byte address of the load
//   mem_req_valid/addr word-aligned cache read request
//   mem_req_ready      cache accepts the read
//   mem_rsp_valid/data cache read data
//   rsp_valid          one-cycle result pulse, no backpressure
//   rsp_data           aligned/extended result, held until next response
//   rsp_misaligned     result is a misaligned report, not a load
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a request, req_ready=1
//   S_REQ0  | issuing read of the base word
//   S_WAIT0 | waiting for the base word
//   S_REQ1  | issuing read of the following word (split loads)
//   S_WAIT1 | waiting for the following word
//   S_RESP  | rsp_valid pulse with registered result
// ---------------------------------------------------------------------------
module load_align_unit #(
    parameter int XLEN             = 32,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_misaligned
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]      state_q;
    logic [2:0]      f3_q;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] base_q;
    logic            split_q;
    logic [XLEN-1:0] lo_q;

    logic [OFFW-1:0] req_off;
    logic [XLEN-1:0] req_base;
    logic [4:0]      req_span;
    logic            req_split;

    // LD and LWU do not exist on a 32-bit datapath; they fall back to a raw
    // word read together with 111.
    function automatic logic is_legal(input logic [2:0] f3);
        if (f3 == 3'b111) return 1'b0;
        if ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        if (!is_legal(f3)) return 4'(BYTES);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // Merge, shift down to the byte offset, trim to size and extend.
    // funct3[2]=0 selects sign extension; for a full-width load the extension
    // mask is empty so LD passes through untouched.
    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] hi,
        input logic [OFFW-1:0] off,
        input logic [2:0]      f3
    );
        logic [2*XLEN-1:0] shifted;
        logic [XLEN-1:0]   mask;
        logic [XLEN-1:0]   msb;
        logic [XLEN-1:0]   val;
        int                nbits;
        if (!is_legal(f3)) return lo;
        shifted = {hi, lo} >> {off, 3'b000};
        nbits   = 8 * int'(size_bytes(f3));
        mask    = {XLEN{1'b1}} >> (XLEN - nbits);
        msb     = mask & ~(mask >> 1);
        val     = shifted[XLEN-1:0] & mask;
        if (!f3[2] && (|(val & msb))) val = val | ~mask;
        return val;
    endfunction

    always_comb begin
        req_off   = req_addr[OFFW-1:0];
        req_base  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
        req_span  = 5'(req_off) + 5'(size_bytes(req_funct3));
        req_split = is_legal(req_funct3) && (req_span > 5'(BYTES));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            f3_q           <= 3'd0;
            off_q          <= '0;
            base_q         <= '0;
            split_q        <= 1'b0;
            lo_q           <= '0;
            rsp_data       <= '0;
            rsp_misaligned <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q    <= req_funct3;
                        off_q   <= req_off;
                        base_q  <= req_base;
                        split_q <= req_split;
                        if (req_split && !MISALIGNED_SPLIT) begin
                            rsp_data       <= '0;
                            rsp_misaligned <= 1'b1;
                            state_q        <= S_RESP;
                        end else begin
                            state_q <= S_REQ0;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_req_ready) state_q <= S_WAIT0;
                end
                S_WAIT0: begin
                    if (mem_rsp_valid) begin
                        lo_q <= mem_rsp_data;
                        if (split_q) begin
                            state_q <= S_REQ1;
                        end else begin
                            rsp_data       <= extract(mem_rsp_data, '0, off_q, f3_q);
                            rsp_misaligned <= 1'b0;
                            state_q        <= S_RESP;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_req_ready) state_q <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (mem_rsp_valid) begin
                        rsp_data       <= extract(lo_q, mem_rsp_data, off_q, f3_q);
                        rsp_misaligned <= 1'b0;
                        state_q        <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_misaligned <= 1'b0;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready     = (state_q == S_IDLE);
        rsp_valid     = (state_q == S_RESP);
        mem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
        case (state_q)
            S_REQ0:  mem_req_addr = base_q;
            S_REQ1:  mem_req_addr = base_q + XLEN'(BYTES);
            default: mem_req_addr = '0;
        endcase
    end

endmodule
